// File: rtl/ring_bus_pkg.sv
// Shared ring encodings used by the master and the register blocks on the ring.
// Holds the control-bit positions, the R/W values, the default widths and the master state type.
package ring_bus_pkg;

    localparam int RING_DATA_W = 8;
    localparam int RING_ADDR_W = 8;

    localparam logic RING_READ  = 1'b1;
    localparam logic RING_WRITE = 1'b0;

    localparam int CTRL_RW  = 1;
    localparam int CTRL_ACK = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ring_state_e;

    // Control word as driven by an initiator; the ACK bit is always left clear.
    function automatic logic [1:0] ring_ctrl(input logic rw);
        logic [1:0] c;
        c          = 2'b00;
        c[CTRL_RW] = rw;
        return c;
    endfunction

endpackage

// File: rtl/ring_bus_master_if.sv
// Host request/response handshake plus the ring head/tail signals of the ring master.
// The master modport is the master's view; slave is the host plus ring side.
interface ring_bus_master_if
    import ring_bus_pkg::*;
#(
    parameter int DATA_W = RING_DATA_W,
    parameter int ADDR_W = RING_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] ring_addr;
    logic [DATA_W-1:0] ring_d_out;
    logic [1:0]        ring_ctrl_out;
    logic [DATA_W-1:0] ring_d_in;
    logic [1:0]        ring_ctrl_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, ring_d_in, ring_ctrl_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ring_addr, ring_d_out, ring_ctrl_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, ring_d_in, ring_ctrl_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ring_addr, ring_d_out, ring_ctrl_out
    );

endinterface

// File: rtl/ring_timeout_counter.sv
// Cycle counter for the ACK wait window; o_tc is high while the count sits at TIMEOUT-1.
// Clear has priority over enable; TIMEOUT must lie in 2..255 so the count fits 8 bits.
module ring_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_tc = (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ring_bus_master.sv
// Ring initiator: one outstanding host request, response pulse 2..TIMEOUT+1 cycles after accept, req_ready low until then.
// Defining RING_MASTER_STATS_EN adds the err_count/txn_count outputs.
module ring_bus_master
    import ring_bus_pkg::*;
#(
    parameter int DATA_W  = RING_DATA_W,
    parameter int ADDR_W  = RING_ADDR_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ring_bus_master_if.master bus
`ifdef RING_MASTER_STATS_EN
    ,
    output logic [7:0]        err_count,
    output logic [15:0]       txn_count
`endif
);
    ring_state_e       r_state;
    ring_state_e       w_next;

    logic              r_is_read;
    logic [ADDR_W-1:0] r_ring_addr;
    logic [DATA_W-1:0] r_ring_d;
    logic [1:0]        r_ring_ctrl;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_ready;
    logic              w_rsp_valid;
    logic              w_accept;
    logic              w_ack;
    logic              w_tc;
    logic              w_done;
    logic              w_unused_rw;

    assign w_ack    = bus.ring_ctrl_in[CTRL_ACK];
    assign w_accept = bus.req_valid && w_ready;
    // ACK outranks the terminal count, so a late ACK still completes successfully.
    assign w_done   = w_ack || w_tc;

    // Responders rewrite R/W on the way back, so it carries no completion information.
    assign w_unused_rw = bus.ring_ctrl_in[CTRL_RW];

    ring_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  ((r_state == WAIT) && !w_done),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = WAIT;
            WAIT:    if (w_done)   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE:    w_ready     = 1'b1;
            RESP:    w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_read   <= 1'b0;
            r_ring_addr <= '0;
            r_ring_d    <= '0;
            r_ring_ctrl <= 2'b00;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_read   <= !bus.req_write;
                        r_ring_addr <= bus.req_addr;
                        r_ring_ctrl <= ring_ctrl(bus.req_write ? RING_WRITE : RING_READ);
                        r_ring_d    <= bus.req_write ? bus.req_wdata : '0;
                    end
                end
                WAIT: begin
                    // Response fields and idle ring values are both set on the way into RESP.
                    if (w_done) begin
                        r_rsp_rdata <= (w_ack && r_is_read) ? bus.ring_d_in : '0;
                        r_rsp_err   <= !w_ack;
                        r_ring_addr <= '0;
                        r_ring_d    <= '0;
                        r_ring_ctrl <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.rsp_valid     = w_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.ring_addr     = r_ring_addr;
    assign bus.ring_d_out    = r_ring_d;
    assign bus.ring_ctrl_out = r_ring_ctrl;

`ifdef RING_MASTER_STATS_EN
    logic [7:0]  r_err_count;
    logic [15:0] r_txn_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'd0;
            r_txn_count <= 16'd0;
        end else if (w_rsp_valid) begin
            r_txn_count <= r_txn_count + 16'd1;
            if (r_rsp_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign err_count = r_err_count;
    assign txn_count = r_txn_count;
`endif

endmodule

// File: tb/tb_ring_bus_master.sv
// Directed bench for ring_bus_master: a responder model on the ring and a scoreboard of expected responses.
module tb_ring_bus_master;
    import ring_bus_pkg::*;

    localparam int TO = 16;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         acc;
        logic [7:0] raddr;
        logic [1:0] rctrl;
        logic [7:0] rd;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ring_bus_master_if #(.DATA_W(8), .ADDR_W(8)) bus ();

`ifdef RING_MASTER_STATS_EN
    logic [7:0]  err_count;
    logic [15:0] txn_count;
`endif

    ring_bus_master #(
        .DATA_W  (8),
        .ADDR_W  (8),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RING_MASTER_STATS_EN
        ,
        .err_count (err_count),
        .txn_count (txn_count)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t e;

    logic [7:0] model_mem [256];
    logic [7:0] ring_mem  [256];
    int   ack_at   = 1;
    bit   idle_ack = 1'b0;
    int   wcnt     = 0;
    bit   chk_idle = 1'b0;
    int   n_rsp    = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ring model: blocks at 0x00..0x3F ACK on the ack_at-th WAIT sample; other addresses are empty.
    always @(negedge clk) begin
        if (!rst_n || bus.req_ready || bus.rsp_valid) begin
            wcnt             = 0;
            bus.ring_ctrl_in = idle_ack ? 2'b01 : 2'b10;
            bus.ring_d_in    = 8'h3C;
        end else begin
            wcnt++;
            if (wcnt == ack_at && bus.ring_addr < 8'h40) begin
                bus.ring_ctrl_in = 2'b01;
                if (bus.ring_ctrl_out[CTRL_RW] == RING_READ) begin
                    bus.ring_d_in = ring_mem[bus.ring_addr];
                end else begin
                    ring_mem[bus.ring_addr] = bus.ring_d_out;
                    bus.ring_d_in           = 8'h3C;
                end
            end else begin
                bus.ring_ctrl_in = 2'b10;
                bus.ring_d_in    = 8'h3C;
            end
        end
    end

    // Response monitor: pops the scoreboard on each rsp_valid and watches the ring head while waiting.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_idle) begin
                chk_idle = 1'b0;
                chk("idle_ready", 32'(bus.req_ready), 32'd1);
                chk("idle_ring_ctrl", 32'(bus.ring_ctrl_out), 32'd0);
                chk("idle_ring_addr", 32'(bus.ring_addr), 32'd0);
                chk("idle_ring_d", 32'(bus.ring_d_out), 32'd0);
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
                    chk("rsp_ready_low", 32'(bus.req_ready), 32'd0);
                    n_rsp++;
                    if (e.err) n_err++;
                    chk_idle = 1'b1;
                end
            end else if (!bus.req_ready && sb.size() > 0) begin
                chk("wait_ring_addr", 32'(bus.ring_addr), 32'(sb[0].raddr));
                chk("wait_ring_ctrl", 32'(bus.ring_ctrl_out), 32'(sb[0].rctrl));
                chk("wait_ring_d", 32'(bus.ring_d_out), 32'(sb[0].rd));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_ring_addr"}, 32'(bus.ring_addr), 32'd0);
        chk({tag, "_ring_d"}, 32'(bus.ring_d_out), 32'd0);
        chk({tag, "_ring_ctrl"}, 32'(bus.ring_ctrl_out), 32'd0);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] wd, input bit hold);
        exp_t x;
        bit   ok = 1'b0;
        bit   present;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_bound", 32'(ok), 32'd1);
        present = (addr < 8'h40) && (ack_at <= TO);
        x.acc   = cyc + 1;
        x.raddr = addr;
        x.rctrl = wr ? 2'b00 : 2'b10;
        x.rd    = wr ? wd : 8'h00;
        if (!present) begin
            x.rdata = 8'h00;
            x.err   = 1'b1;
            x.lat   = TO + 1;
        end else if (wr) begin
            x.rdata         = 8'h00;
            x.err           = 1'b0;
            x.lat           = ack_at + 1;
            model_mem[addr] = wd;
        end else begin
            x.rdata = model_mem[addr];
            x.err   = 1'b0;
            x.lat   = ack_at + 1;
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_bound", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'h00;
            ring_mem[i]  = 8'h00;
        end
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write 0x05 <= 0xA5, ACK on the second WAIT sample.
        ack_at = 2;
        issue(1'b1, 8'h05, 8'hA5, 1'b0);
        drain();

        // Read it back with the fastest possible ACK.
        ack_at = 1;
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        drain();

        // Empty address: timeout after TO cycles; a stale ACK in IDLE must be ignored.
        idle_ack = 1'b1;
        ack_at   = 100;
        issue(1'b0, 8'h7F, 8'h00, 1'b0);
        drain();
        idle_ack = 1'b0;

        // One cycle too late for the window.
        ack_at = TO + 1;
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        drain();

        // ACK on the same sample as the terminal count.
        ack_at = TO;
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        drain();
        chk("rdata_held", 32'(bus.rsp_rdata), 32'hA5);

        // Reset in WAIT during a read abandons it.
        ack_at = 100;
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        sb.delete();
        n_rsp = 0;
        n_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_ready", 32'(bus.req_ready), 32'd1);

        ack_at = 3;
        issue(1'b0, 8'h05, 8'h00, 1'b0);
        drain();

        // Back-to-back with req_valid held high across three requests.
        ack_at = 1;
        issue(1'b1, 8'h20, 8'h11, 1'b1);
        issue(1'b1, 8'h21, 8'h22, 1'b1);
        issue(1'b0, 8'h20, 8'h00, 1'b0);
        drain();
        chk("b2b_responses", 32'(n_rsp), 32'd4);

`ifdef RING_MASTER_STATS_EN
        chk("txn_count", 32'(txn_count), 32'(n_rsp));
        chk("err_count", 32'(err_count), 32'(n_err));
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_bus_master.md
Name: ring_bus_master

Overview:
- Initiator for the daisy-chained register ring. Each register block on the ring compares the ring address against its own, and then either serves the transaction or passes it through unchanged.
- Accepts one read or write request at a time from a host valid/ready port and drives it onto the ring head.
- Watches the ring tail for the ACK bit, then returns read data or completion status to the host.
- Flags a timeout error if no block acknowledges within a bounded window.

Parameters:
- DATA_W, 8, ring data width.
- ADDR_W, 8, ring address width.
- TIMEOUT, 16, cycles to wait for ACK before declaring an error (legal range 2..255).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  master idle and able to accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target register address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  1 = no ACK within TIMEOUT cycles.
- ring_addr  out  ADDR_W  address driven to the ring head.
- ring_d_out  out  DATA_W  data driven to the ring head.
- ring_ctrl_out  out  2  {R/W, ACK} to the ring head; Read = 1, Write = 0.
- ring_d_in  in  DATA_W  data returned from the ring tail.
- ring_ctrl_in  in  2  {R/W, ACK} returned from the ring tail.

Behaviour:
- Reset values (async, rst_n low):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - ring_addr = 0, ring_d_out = 0, ring_ctrl_out = 2'b00.
  - Timeout counter = 0.
- Ring outputs are registered, never z. The ACK bit the master drives is always 0.
- State machine:
  - IDLE: req_ready = 1. On req_valid & req_ready, latch req_addr/req_wdata/req_write.
    - Drive ring_addr = req_addr.
    - Drive ring_ctrl_out = {~req_write, 0}.
    - Drive ring_d_out = req_wdata for writes, 0 for reads.
    - Clear the counter and go to WAIT.
  - WAIT: req_ready = 0, ring outputs held stable. Each cycle, sample ring_ctrl_in.
    - If ring_ctrl_in[0] = 1 (ACK): capture ring_d_in into rsp_rdata if the op was a read (else 0), set rsp_err = 0, go to RESP.
    - Else if counter == TIMEOUT-1: set rsp_rdata = 0, rsp_err = 1, go to RESP.
    - Else increment the counter.
  - RESP: rsp_valid = 1 for exactly one cycle.
    - Ring outputs return to idle: ring_ctrl_out = 2'b00, ring_addr = 0, ring_d_out = 0.
    - Go to IDLE. rsp_rdata and rsp_err hold until the next response.
- Timing and handshake:
  - Minimum latency: accept at edge N, earliest rsp_valid at edge N+2 (ACK seen at the first WAIT sample).
  - Fixed by design: an ACK arriving on the same cycle as the counter reaching TIMEOUT-1 wins (success, not error).
  - The R/W bit in ring_ctrl_in is ignored for completion. Responders rewrite it to Write on read ACK.
  - Host may drop req_valid at any time. A request is consumed only on a valid & ready cycle.
  - req_ready is 0 in WAIT and RESP, and returns to 1 in the IDLE cycle after RESP. Max one outstanding transaction.
- rst_n asserted mid-transaction: the transaction is abandoned, no response is generated, and all outputs take their reset values immediately.
- ring_ctrl_in ACK seen while in IDLE or RESP: ignored (stale or idle ring).

Optional Feature:
- Macro RING_MASTER_STATS_EN.
- When defined, add output err_count[7:0]. It increments on every timeout response, saturates at 255, and resets to 0 on rst_n.
- Also add output txn_count[15:0]. It increments on every rsp_valid, wraps at 65535 -> 0, and resets to 0.
- When undefined, neither port nor counter exists and the remaining behaviour is identical.

Decomposition:
- Shared package ring_bus_pkg holds:
  - RING_READ = 1'b1, RING_WRITE = 1'b0.
  - Control bit indices CTRL_RW = 1, CTRL_ACK = 0.
  - Default widths DATA_W/ADDR_W.
  - State enum {IDLE, WAIT, RESP}.
- The register blocks import the same package for the encodings.
- One natural sub-module, ring_timeout_counter: clear/enable inputs and a terminal-count output at TIMEOUT-1, parameterised by TIMEOUT.

Test Plan:
- Write addr 0x05 data 0xA5; a responder at 0x05 returns ctrl 2'b01 on the 2nd WAIT cycle. Expect ring_ctrl_out = 2'b00 while waiting, rsp_valid for 1 cycle, rsp_err = 0, rsp_rdata = 0.
- Read addr 0x05 after that write; responder returns d_in 0xA5 with ctrl 2'b01. Expect ring_ctrl_out = 2'b10, then rsp_rdata = 0xA5, rsp_err = 0.
- Read addr 0x7F with no responder (ctrl_in tied 2'b10), TIMEOUT = 16. Expect rsp_valid with rsp_err = 1 and rsp_rdata = 0 exactly 17 cycles after acceptance.
- ACK asserted on the same cycle the counter reaches TIMEOUT-1. Expect rsp_err = 0 and data captured.
- Assert rst_n low in WAIT during a read. Expect immediate reset values, no rsp_valid, and req_ready = 1 after release. A following read still works.
- Back-to-back: hold req_valid high with 3 requests. Expect req_ready low during WAIT/RESP, exactly 3 rsp_valid pulses in order. With RING_MASTER_STATS_EN, txn_count = 3.
